// File: rtl/codec_cfg_sequencer_if.sv
// Command port between the codec configuration sequencer and the I2C master.
// The master modport is the command source; the slave modport is the I2C master.
interface codec_cfg_sequencer_if;
  logic       Write;
  logic [7:0] SubAddrL;
  logic [7:0] data;
  logic       ready;
  logic       error;

  modport master (output Write, output SubAddrL, output data, input ready, input error);
  modport slave  (input Write, input SubAddrL, input data, output ready, output error);
endinterface

// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: plays the init ROM, then serves runtime register writes,
// one I2C transaction at a time. Optional per-command retry via `CODEC_CFG_RETRY_EN.
module codec_cfg_sequencer #(
  parameter int NUM_INIT    = 32,
  parameter int ROM_AW      = 6,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 3
) (
  input  logic                  I2C_clk,
  input  logic                  reset,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [15:0]           rom_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_addr,
  input  logic [7:0]            req_data,
  output logic                  cmd_done,
  output logic                  cmd_err,
  output logic                  init_done,
  output logic                  init_err,
  codec_cfg_sequencer_if.master i2c
);

  localparam int                TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]     TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [ROM_AW-1:0] LAST_ENTRY = ROM_AW'(NUM_INIT - 1);
  localparam bit                NO_INIT    = (NUM_INIT == 0);

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CHECK
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [7:0]        r_addr;
  logic [7:0]        r_data;
  logic              r_init_done;
  logic              r_init_err;
  logic              r_err;
  logic [TW-1:0]     r_tmo;

  logic w_write;
  logic w_req_ready;
  logic w_accept;
  logic w_finish;
  logic w_cmd_done;
  logic w_tmo_err;
  logic w_timeout;
  logic w_last;

`ifdef CODEC_CFG_RETRY_EN
  localparam int            RW         = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  logic [RW-1:0] r_retry;
  logic          w_retry;
`else
  logic w_unused_retry;
  assign w_unused_retry = (MAX_RETRY != 0);
`endif

  assign w_timeout = (r_tmo == TMO_LAST);
  assign w_last    = (r_rom_addr == LAST_ENTRY);

  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    w_req_ready  = 1'b0;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_cmd_done   = 1'b0;
    w_tmo_err    = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
    w_retry      = 1'b0;
`endif
    case (r_state)
      S_LOAD: w_state_next = S_ISSUE;
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i2c.ready) begin
          w_write      = 1'b1;
          w_state_next = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!i2c.ready) begin
          w_state_next = S_WAIT_DONE;
        end else if (w_timeout) begin
          w_tmo_err    = 1'b1;
          w_state_next = S_CHECK;
        end
      end
      S_WAIT_DONE: begin
        if (i2c.ready) begin
          w_state_next = S_CHECK;
        end else if (w_timeout) begin
          w_tmo_err    = 1'b1;
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
`ifdef CODEC_CFG_RETRY_EN
        if (r_err && (r_retry != RETRY_LAST)) begin
          w_retry      = 1'b1;
          w_state_next = S_ISSUE;
        end else begin
          w_finish = 1'b1;
        end
`else
        w_finish = 1'b1;
`endif
        if (w_finish) begin
          if (r_init_done) begin
            w_cmd_done   = 1'b1;
            w_state_next = S_IDLE;
          end else if (w_last) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_LOAD;
          end
        end
      end
      default: w_state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge I2C_clk) begin
    if (!reset) begin
      r_state <= NO_INIT ? S_IDLE : S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge I2C_clk) begin
    if (!reset) begin
      r_rom_addr  <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_init_done <= NO_INIT;
      r_init_err  <= 1'b0;
      r_err       <= 1'b0;
      r_tmo       <= '0;
    end else begin
      if (r_state == S_LOAD) begin
        {r_addr, r_data} <= rom_data;
      end else if (w_accept) begin
        r_addr <= req_addr;
        r_data <= req_data;
      end

      // error counts only on the ready-rise cycle of WAIT_DONE
      if (w_write) begin
        r_err <= 1'b0;
      end else if ((r_state == S_WAIT_DONE) && i2c.ready) begin
        r_err <= i2c.error;
      end else if (w_tmo_err) begin
        r_err <= 1'b1;
      end

      if (w_state_next != r_state) begin
        r_tmo <= '0;
      end else if ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) begin
        r_tmo <= r_tmo + 1'b1;
      end

      if (w_finish && !r_init_done) begin
        if (r_err) begin
          r_init_err <= 1'b1;
        end
        if (w_last) begin
          r_init_done <= 1'b1;
        end else begin
          r_rom_addr <= r_rom_addr + 1'b1;
        end
      end
    end
  end

`ifdef CODEC_CFG_RETRY_EN
  always_ff @(posedge I2C_clk) begin
    if (!reset) begin
      r_retry <= '0;
    end else if (w_retry) begin
      r_retry <= r_retry + 1'b1;
    end else if (w_finish) begin
      r_retry <= '0;
    end
  end
`endif

  assign rom_addr     = r_rom_addr;
  assign req_ready    = w_req_ready;
  assign cmd_done     = w_cmd_done;
  assign cmd_err      = w_cmd_done & r_err;
  assign init_done    = r_init_done;
  assign init_err     = r_init_err;
  assign i2c.Write    = w_write;
  assign i2c.SubAddrL = r_addr;
  assign i2c.data     = r_data;

endmodule
